// File: rtl/oam_dma_if.sv
// Memory-bus handshake between the OAM DMA engine (master) and the arbiter/memory side (slave).
// The bidirectional data bus stays a plain inout on the engine so the tristate net resolves at top level.
interface oam_dma_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] addr_ext;
    logic        mem_we;
    logic        mem_re;

    modport master (
        output bus_req,
        output addr_ext,
        output mem_we,
        output mem_re,
        input  bus_gnt
    );

    modport slave (
        input  bus_req,
        input  addr_ext,
        input  mem_we,
        input  mem_re,
        output bus_gnt
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write of a page number copies LENGTH bytes from {page,8'h00}
// to DST_BASE with one read cycle and one write cycle per byte on the shared memory bus.
module oam_dma #(
    parameter logic [15:0] REG_ADDR = 16'hFF46,
    parameter logic [15:0] DST_BASE = 16'hFE00,
    parameter int          LENGTH   = 160
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    oam_dma_if.master   bus,
    inout  wire  [7:0]  data_ext,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    state_t      state_q;
    logic [7:0]  idx_q;
    logic [7:0]  src_hi_q;
    logic [7:0]  buf_q;
    logic [15:0] addr_q;
    logic        req_q;
    logic        re_q;
    logic        we_q;
    logic        active_q;

    logic        start_d;
    logic        gnt_d;
    logic [7:0]  idx_inc_d;
    logic [15:0] dst_addr_d;

    assign start_d    = cpu_we && (cpu_addr == REG_ADDR);
    assign gnt_d      = bus.bus_gnt;
    assign idx_inc_d  = idx_q + 8'd1;
    assign dst_addr_d = DST_BASE + {8'h00, idx_q};

    // Outputs are registered alongside the state; a missing grant only holds everything in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 8'h00;
            src_hi_q <= 8'hFF;
            buf_q    <= 8'h00;
            addr_q   <= 16'h0000;
            req_q    <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            active_q <= 1'b0;
        end else if (start_d) begin
            src_hi_q <= cpu_wdata;
            idx_q    <= 8'h00;
            state_q  <= REQ;
            addr_q   <= 16'h0000;
            req_q    <= 1'b1;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            active_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_q    <= 1'b0;
                    re_q     <= 1'b0;
                    we_q     <= 1'b0;
                    active_q <= 1'b0;
                end
                REQ: begin
                    if (gnt_d) begin
                        state_q <= READ;
                        addr_q  <= {src_hi_q, idx_q};
                        re_q    <= 1'b1;
                    end
                end
                READ: begin
                    if (gnt_d) begin
                        buf_q   <= data_ext;
                        state_q <= WRITE;
                        addr_q  <= dst_addr_d;
                        re_q    <= 1'b0;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (gnt_d) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= IDLE;
                            addr_q   <= 16'h0000;
                            req_q    <= 1'b0;
                            we_q     <= 1'b0;
                            active_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_inc_d;
                            state_q <= READ;
                            addr_q  <= {src_hi_q, idx_inc_d};
                            re_q    <= 1'b1;
                            we_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req  = req_q;
    assign bus.addr_ext = addr_q;
    assign bus.mem_re   = re_q & gnt_d;
    assign bus.mem_we   = we_q & gnt_d;
    assign data_ext     = (we_q && gnt_d) ? buf_q : 8'hzz;
    assign dma_active   = active_q;
    assign cpu_rdata    = (cpu_re && (cpu_addr == REG_ADDR)) ? src_hi_q : 8'h00;

endmodule
